// File: rtl/hack_screen_scanout_if.sv
// Screen-memory read port between the scanout pipeline (master) and the Hack screen RAM (slave).
interface hack_screen_scanout_if;
   logic [12:0] ram_addr;
   logic        ram_en;
   logic [15:0] ram_rdata;

   modport master (output ram_addr, output ram_en, input ram_rdata);
   modport slave  (input ram_addr, input ram_en, output ram_rdata);
endinterface

// File: rtl/hack_screen_scanout.sv
// Hack 512x256 1bpp screen scanout: 3-stage counters-to-pixel pipeline with matched sync delay.
// Optional frame around the window when SCANOUT_BORDER_EN is defined.
module hack_screen_scanout #(
   parameter int          X_OFF    = 64,
   parameter int          Y_OFF    = 112,
   parameter logic [2:0]  FG_COLOR = 3'b010,
   parameter logic [2:0]  BG_COLOR = 3'b000
`ifdef SCANOUT_BORDER_EN
   ,
   parameter logic [2:0]  BORDER_COLOR = 3'b100
`endif
) (
   input  logic                   clk_25,
   input  logic                   rst_n,
   input  logic [9:0]             CounterX,
   input  logic [9:0]             CounterY,
   input  logic                   inDisplayArea,
   input  logic                   hsync_in,
   input  logic                   vsync_in,
   hack_screen_scanout_if.master  ram,
   output logic [2:0]             pixel,
   output logic                   hsync_out,
   output logic                   vsync_out
);

   localparam logic [9:0] X_LO = 10'(X_OFF);
   localparam logic [9:0] X_HI = 10'(X_OFF + 512);
   localparam logic [9:0] Y_LO = 10'(Y_OFF);
   localparam logic [9:0] Y_HI = 10'(Y_OFF + 256);

   logic       in_win;
   logic       word_start;
   logic [8:0] rx;
   logic [7:0] ry;
   logic       border;

   // Window compare uses the full 10-bit counters; rx/ry are only consumed inside the window.
   assign in_win     = inDisplayArea &&
                       (CounterX >= X_LO) && (CounterX < X_HI) &&
                       (CounterY >= Y_LO) && (CounterY < Y_HI);
   assign rx         = CounterX[8:0] - X_LO[8:0];
   assign ry         = CounterY[7:0] - Y_LO[7:0];
   assign word_start = in_win && (rx[3:0] == 4'd0);

`ifdef SCANOUT_BORDER_EN
   logic [10:0] cx1;
   logic [10:0] cy1;
   logic        span_x;
   logic        span_y;
   logic        on_rows;
   logic        on_cols;

   // Offset by one so the X_OFF-1 / Y_OFF-1 edges compare without underflow.
   assign cx1     = {1'b0, CounterX} + 11'd1;
   assign cy1     = {1'b0, CounterY} + 11'd1;
   assign span_x  = (cx1 >= 11'(X_OFF)) && (CounterX <= X_HI);
   assign span_y  = (cy1 >= 11'(Y_OFF)) && (CounterY <= Y_HI);
   assign on_rows = (cy1 == 11'(Y_OFF)) || (CounterY == Y_HI);
   assign on_cols = (cx1 == 11'(X_OFF)) || (CounterX == X_HI);
   assign border  = inDisplayArea && ((on_rows && span_x) || (on_cols && span_y));
`else
   assign border  = 1'b0;
`endif

   logic        in_win_a;
   logic        de_a;
   logic [3:0]  phase_a;
   logic        hs_a;
   logic        vs_a;
   logic        border_a;

   logic        in_win_b;
   logic        de_b;
   logic        bit_b;
   logic [15:0] shreg;
   logic        hs_b;
   logic        vs_b;
   logic        border_b;

   always_ff @(posedge clk_25 or negedge rst_n) begin
      if (!rst_n) begin
         ram.ram_en   <= 1'b0;
         ram.ram_addr <= '0;
         in_win_a     <= 1'b0;
         de_a         <= 1'b0;
         phase_a      <= '0;
         hs_a         <= 1'b1;
         vs_a         <= 1'b1;
         border_a     <= 1'b0;
      end else begin
         ram.ram_en <= word_start;
         if (word_start)
            ram.ram_addr <= {ry, rx[8:4]};
         in_win_a <= in_win;
         de_a     <= inDisplayArea;
         phase_a  <= rx[3:0];
         hs_a     <= hsync_in;
         vs_a     <= vsync_in;
         border_a <= border;
      end
   end

   // ram_rdata is only looked at on a word-start cycle, i.e. while ram_en is high.
   always_ff @(posedge clk_25 or negedge rst_n) begin
      if (!rst_n) begin
         in_win_b <= 1'b0;
         de_b     <= 1'b0;
         bit_b    <= 1'b0;
         shreg    <= '0;
         hs_b     <= 1'b1;
         vs_b     <= 1'b1;
         border_b <= 1'b0;
      end else begin
         if (in_win_a && (phase_a == 4'd0)) begin
            bit_b <= ram.ram_rdata[0];
            shreg <= {1'b0, ram.ram_rdata[15:1]};
         end else if (in_win_a) begin
            bit_b <= shreg[0];
            shreg <= {1'b0, shreg[15:1]};
         end
         in_win_b <= in_win_a;
         de_b     <= de_a;
         hs_b     <= hs_a;
         vs_b     <= vs_a;
         border_b <= border_a;
      end
   end

   logic [2:0] pixel_next;

   always_comb begin
      pixel_next = 3'b000;
      if (in_win_b)
         pixel_next = bit_b ? FG_COLOR : BG_COLOR;
`ifdef SCANOUT_BORDER_EN
      else if (border_b)
         pixel_next = BORDER_COLOR;
`endif
      else if (de_b)
         pixel_next = BG_COLOR;
   end

   always_ff @(posedge clk_25 or negedge rst_n) begin
      if (!rst_n) begin
         pixel     <= 3'b000;
         hsync_out <= 1'b1;
         vsync_out <= 1'b1;
      end else begin
         pixel     <= pixel_next;
         hsync_out <= hs_b;
         vsync_out <= vs_b;
      end
   end

`ifndef SCANOUT_BORDER_EN
   logic unused_border;
   assign unused_border = border_b;
`endif

endmodule
